sync_filter_bank: RTL and testbench
===================================

SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent channels, legal range 1..32.
REQ-002 Parameter STAGES, default 3: total flip-flops in each channel's path, including the output register; legal range 2..4.
REQ-003 Parameter FILTER_CYCLES, default 4: consecutive stable cycles required before the output changes when filtering is enabled; legal range 1..255.
REQ-004 Parameter RESET_VALUE, default {WIDTH{1'b0}}: the value of output_sync during reset.
REQ-005 Port clk, input, 1 bit: the single clock; all flip-flops are rising-edge.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port input_async, input, WIDTH bits: asynchronous channel inputs.
REQ-008 Port filter_en, input, 1 bit, synchronous to clk: 1 enables the glitch filter, 0 selects bypass.
REQ-009 Port output_sync, output, WIDTH bits: registered, synchronized and filtered channel values.
REQ-010 Port rise, output, WIDTH bits: registered one-cycle pulse on each 0->1 change of output_sync.
REQ-011 Port fall, output, WIDTH bits: registered one-cycle pulse on each 1->0 change of output_sync.
REQ-012 Port changed, output, 1 bit: registered; equals OR of rise and fall.

Function
REQ-013 Each channel SHALL have a chain of STAGES-1 synchronizer flops; the last of these is sync_last[i].
REQ-014 Bypass (filter_en=0): output_sync[i] SHALL load sync_last[i] every edge, giving STAGES edges of latency (3 with the defaults).
REQ-015 Filter (filter_en=1): each channel SHALL have a counter of width clog2(FILTER_CYCLES), minimum 1 bit.
- When sync_last[i] differs from output_sync[i], the counter increments.
- When they are equal, the counter clears to 0.
REQ-016 When sync_last[i] differs from output_sync[i] and cnt[i] equals FILTER_CYCLES-1, output_sync[i] SHALL load sync_last[i] and cnt[i] SHALL clear.
- Latency is therefore STAGES-1+FILTER_CYCLES edges.
- FILTER_CYCLES=1 SHALL behave identically to bypass.
REQ-017 A glitch whose width at sync_last is shorter than FILTER_CYCLES cycles SHALL leave output_sync unchanged; the counter restarts from 0 after the glitch.
REQ-018 While filter_en=0, all counters SHALL be held at 0.
- A change of filter_en takes effect at the next edge.
- Enabling the filter never causes an immediate output change.
REQ-019 rise[i] and fall[i] SHALL be registered in the same edge in which output_sync[i] updates, and SHALL be high for exactly one cycle.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-021 No combinational path SHALL exist from any input to any output.

Reset
REQ-022 While reset_n=0, all of the following SHALL hold:
- synchronizer flops = 0
- counters = 0
- output_sync = RESET_VALUE
- rise, fall, changed = 0
REQ-023 Reset asserted mid-count SHALL discard all partial counts.
REQ-024 After reset_n deasserts, the first edge SHALL behave as a normal edge.
- A channel whose input differs from its RESET_VALUE bit produces a rise or fall pulse when the output updates.

Configuration
REQ-025 Macro SYNC_FILTER_BANK_EDGE_DETECT_EN defined: rise, fall and changed are generated per REQ-019.
REQ-026 Macro undefined: rise, fall and changed SHALL be tied to 0 with no edge-detect flops; ports remain present and all other behaviour is unchanged.

Verification (WIDTH=4, STAGES=3, FILTER_CYCLES=4, RESET_VALUE=4'h0, macro defined unless noted)
REQ-027 Reset: reset_n=0 with input_async=4'hF -> output_sync=4'h0 and rise=0. Release reset with filter_en=0 -> output_sync=4'hF on the 3rd edge, with rise=4'hF for 1 cycle and changed=1.
REQ-028 Glitch rejection: filter_en=1, input_async[0] high for 2 cycles -> output_sync[0] stays 0 and rise[0] is never asserted.
REQ-029 Filtered step: filter_en=1, input_async[1] 0->1 and held -> output_sync[1]=1 on the 6th edge after capture, with a single-cycle rise[1] pulse on the same edge.
REQ-030 Simultaneous events: ch2 0->1 and ch3 1->0 at the same edge -> rise=4'b0100 and fall=4'b1000 in the same cycle, changed=1.
REQ-031 Mid-count reset: pulse reset_n low when cnt=2 -> after release, an input held high needs the full 4 stable cycles before the output changes.
REQ-032 Macro undefined: repeat REQ-029 -> output_sync timing is identical, and rise, fall and changed remain 0 throughout.

Source files
------------

// File: rtl/sync_filter_bank.sv
// sync_filter_bank: a bank of independent single-bit synchronizers, each with
// an optional glitch filter and registered rise/fall/changed edge pulses.
//
// Each channel has STAGES-1 synchronizer flops followed by an output register.
// With filter_en=0 the output register copies the last synchronizer flop on
// every edge. With filter_en=1 it copies it only after the synchronized value
// has differed from the output for FILTER_CYCLES consecutive edges.
//
// Build option: define SYNC_FILTER_BANK_EDGE_DETECT_EN to generate the
// rise/fall/changed pulses. Without it those ports are tied to 0 and no
// edge-detect flops exist.
module sync_filter_bank #(
    parameter int               WIDTH         = 8,
    parameter int               STAGES        = 3,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] input_async,
    input  logic             filter_en,
    output logic [WIDTH-1:0] output_sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Counter must hold 0..FILTER_CYCLES-1; at least one bit even for 1.
    localparam int               CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam int               SYNC_N   = STAGES - 1;

    logic [SYNC_N-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             sync_last;
    logic [WIDTH-1:0]             out_q;
    logic [WIDTH-1:0]             out_d;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_d;

    assign sync_last   = sync_q[SYNC_N-1];
    assign output_sync = out_q;

    // Synchronizer chain: stage 0 samples the asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= input_async;
            for (int k = 1; k < SYNC_N; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-channel filter: count consecutive mismatching edges, load the
    // output when the count reaches FILTER_CYCLES-1 with the mismatch still
    // present. Bypass loads every edge and keeps the counters cleared, so
    // enabling the filter always starts a fresh count.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!filter_en) begin
                out_d[i] = sync_last[i];
            end else if (sync_last[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i] = sync_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Output register and filter counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= RESET_VALUE;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef SYNC_FILTER_BANK_EDGE_DETECT_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             changed_q;

    // Edge pulses are computed from the output's next value so they are
    // registered on the same edge the output changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= out_d & ~out_q;
            fall_q    <= ~out_d & out_q;
            changed_q <= |(out_d ^ out_q);
        end
    end

    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;
`else
    assign rise    = '0;
    assign fall    = '0;
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank (WIDTH=4, STAGES=3, FILTER_CYCLES=4, RESET_VALUE=0).
// Reference model: history of sampled inputs and filter_en since reset; the
// output of a channel flips when its synchronized value has disagreed with
// the output on each of the last FILTER_CYCLES edges with the filter on.
module tb_sync_filter_bank;

  localparam int         W  = 4;
  localparam int         ST = 3;
  localparam int         FC = 4;
  localparam logic [3:0] RV = 4'h0;

`ifdef SYNC_FILTER_BANK_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] input_async = '0;
  logic         filter_en = 1'b0;
  logic [W-1:0] output_sync;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  always #5 clk = ~clk;

  sync_filter_bank #(
    .WIDTH(W), .STAGES(ST), .FILTER_CYCLES(FC), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .input_async(input_async),
    .filter_en(filter_en), .output_sync(output_sync),
    .rise(rise), .fall(fall), .changed(changed)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] in_hist[$];
  logic [W-1:0] sl_hist[$];
  bit           en_hist[$];
  logic [W-1:0] m_out;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic         m_changed;

  task automatic model_reset();
    in_hist.delete();
    sl_hist.delete();
    en_hist.delete();
    m_out     = RV;
    m_rise    = '0;
    m_fall    = '0;
    m_changed = 1'b0;
  endtask

  // One clock edge with the given sampled inputs.
  task automatic model_edge(input logic [W-1:0] in, input bit en);
    int           n;
    int           idx;
    logic [W-1:0] sl;
    logic [W-1:0] past;
    logic [W-1:0] nxt;
    bit           ok;
    n  = in_hist.size();
    // Value at the end of the synchronizer entering this edge: the input
    // sampled ST-1 edges earlier, or 0 if reset was more recent.
    sl = (n >= ST - 1) ? in_hist[n - (ST - 1)] : '0;
    in_hist.push_back(in);
    sl_hist.push_back(sl);
    en_hist.push_back(en);
    nxt = m_out;
    for (int ch = 0; ch < W; ch++) begin
      if (!en) begin
        nxt[ch] = sl[ch];
      end else begin
        ok = (sl_hist.size() >= FC);
        for (int k = 0; k < FC; k++) begin
          if (ok) begin
            idx  = sl_hist.size() - 1 - k;
            past = sl_hist[idx];
            if (!en_hist[idx] || past[ch] == m_out[ch]) ok = 1'b0;
          end
        end
        if (ok) nxt[ch] = ~m_out[ch];
      end
    end
    m_rise    = EDGE_EN ? (nxt & ~m_out) : '0;
    m_fall    = EDGE_EN ? (~nxt & m_out) : '0;
    m_changed = EDGE_EN ? (nxt != m_out) : 1'b0;
    m_out     = nxt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [W-1:0] in, input bit en);
    input_async = in;
    filter_en   = en;
    model_edge(in, en);
    @(posedge clk);
    #1;
    check("output_sync", 32'(output_sync), 32'(m_out));
    check("rise",        32'(rise),        32'(m_rise));
    check("fall",        32'(fall),        32'(m_fall));
    check("changed",     32'(changed),     32'(m_changed));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"},  32'(output_sync), 32'(RV));
    check({tag, "_rise"}, 32'(rise),        32'h0);
    check({tag, "_fall"}, 32'(fall),        32'h0);
    check({tag, "_chg"},  32'(changed),     32'h0);
  endtask

  // Held reset over several edges; released away from the clock edge.
  task automatic do_reset(input logic [W-1:0] in, input int cycles);
    reset_n     = 1'b0;
    input_async = in;
    filter_en   = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset_async");
    repeat (cycles) @(posedge clk);
    #1;
    check_reset_state("reset_held");
    reset_n = 1'b1;
  endtask

  // Short asynchronous reset pulse between clock edges.
  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    check_reset_state("reset_pulse");
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] rv;
  bit           re;
  int           rlen;

  initial begin
    model_reset();

    // Reset with all inputs high, then bypass: output follows on the 3rd edge.
    do_reset(4'hF, 3);
    for (int i = 1; i <= 5; i++) begin
      step(4'hF, 1'b0);
      if (i == 2) check("bypass_edge2_out", 32'(output_sync), 32'h0);
      if (i == 3) begin
        check("bypass_edge3_out",  32'(output_sync), 32'hF);
        check("bypass_edge3_rise", 32'(rise),        EDGE_EN ? 32'hF : 32'h0);
        check("bypass_edge3_chg",  32'(changed),     EDGE_EN ? 32'h1 : 32'h0);
      end
      if (i == 4) check("bypass_edge4_rise", 32'(rise), 32'h0);
    end

    // Filter on, all inputs low: settle to 0.
    repeat (10) step(4'h0, 1'b1);

    // Two-cycle glitch on channel 0 must be rejected.
    repeat (2) step(4'h1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(4'h0, 1'b1);
      check("glitch_out0", 32'(output_sync[0]), 32'h0);
      check("glitch_rise0", 32'(rise[0]), 32'h0);
    end

    // Filtered step on channel 1: output changes on the 6th edge.
    for (int i = 1; i <= 8; i++) begin
      step(4'b0010, 1'b1);
      if (i == 5) check("fstep_edge5_out1", 32'(output_sync[1]), 32'h0);
      if (i == 6) begin
        check("fstep_edge6_out1",  32'(output_sync[1]), 32'h1);
        check("fstep_edge6_rise1", 32'(rise[1]),        EDGE_EN ? 32'h1 : 32'h0);
      end
      if (i == 7) check("fstep_edge7_rise1", 32'(rise[1]), 32'h0);
    end

    // Raise channel 3, then ch2 0->1 and ch3 1->0 on the same edge.
    repeat (8) step(4'b1010, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0110, 1'b1);
      if (i == 6) begin
        check("simul_rise", 32'(rise),    EDGE_EN ? 32'h4 : 32'h0);
        check("simul_fall", 32'(fall),    EDGE_EN ? 32'h8 : 32'h0);
        check("simul_chg",  32'(changed), EDGE_EN ? 32'h1 : 32'h0);
      end
    end

    // Mid-count reset: count reaches 2 on channel 0, reset discards it.
    repeat (10) step(4'h0, 1'b1);
    repeat (4) step(4'h1, 1'b1);
    pulse_reset();
    for (int i = 1; i <= 7; i++) begin
      step(4'h1, 1'b1);
      if (i == 5) check("midrst_edge5_out0", 32'(output_sync[0]), 32'h0);
      if (i == 6) check("midrst_edge6_out0", 32'(output_sync[0]), 32'h1);
    end

    // Randomized segments: hold lengths, filter toggles, glitches, resets.
    for (int r = 0; r < 120; r++) begin
      rv   = 4'($urandom_range(0, 15));
      re   = ($urandom_range(0, 3) != 0);
      rlen = $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) pulse_reset();
      repeat (rlen) step(rv, re);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
